// File: rtl/rip_csr_pkg.sv
// Shared constants, enums and helper functions for the CSR sequencer.
package rip_csr_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {
    OP_RSVD = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_t;

  typedef enum logic [3:0] {
    S_IDLE, S_C_RD, S_C_WR,
    S_T_EPC, S_T_CAUSE, S_T_TVAL, S_T_VEC, S_T_STAT,
    S_M_EPC, S_M_STAT, S_REDIR
  } csr_seq_state_t;

  // Vectored mode applies only to interrupts; the offset wraps mod 2^XLEN.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                  input logic [XLEN-1:0] cause);
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && cause[XLEN-1])
      return base + XLEN'({cause[XLEN-2:0], 2'b00});
    return base;
  endfunction

  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r               = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r               = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rip_csr_seq_if.sv
// Requester handshakes, redirect/response outputs and CSR file port of the sequencer.
interface rip_csr_seq_if;
  import rip_csr_pkg::*;

  logic              csr_req_valid;
  logic              csr_req_ready;
  logic [1:0]        csr_req_op;
  logic [CSR_AW-1:0] csr_req_addr;
  logic [XLEN-1:0]   csr_req_wdata;
  logic              csr_req_wr_en;
  logic              csr_rsp_valid;
  logic [XLEN-1:0]   csr_rsp_rdata;

  logic              trap_valid;
  logic              trap_ready;
  logic [XLEN-1:0]   trap_pc;
  logic [XLEN-1:0]   trap_cause;
  logic [XLEN-1:0]   trap_tval;

  logic              mret_valid;
  logic              mret_ready;

  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              busy;

  logic              cf_write;
  logic              cf_set;
  logic              cf_clear;
  logic [CSR_AW-1:0] cf_addr;
  logic [XLEN-1:0]   cf_din;
  logic [XLEN-1:0]   cf_dout;

  modport slave (
    input  csr_req_valid, csr_req_op, csr_req_addr, csr_req_wdata, csr_req_wr_en,
           trap_valid, trap_pc, trap_cause, trap_tval, mret_valid, cf_dout,
    output csr_req_ready, csr_rsp_valid, csr_rsp_rdata, trap_ready, mret_ready,
           redirect_valid, redirect_pc, busy, cf_write, cf_set, cf_clear, cf_addr, cf_din
  );

  modport master (
    output csr_req_valid, csr_req_op, csr_req_addr, csr_req_wdata, csr_req_wr_en,
           trap_valid, trap_pc, trap_cause, trap_tval, mret_valid, cf_dout,
    input  csr_req_ready, csr_rsp_valid, csr_rsp_rdata, trap_ready, mret_ready,
           redirect_valid, redirect_pc, busy, cf_write, cf_set, cf_clear, cf_addr, cf_din
  );

endinterface

// File: rtl/rip_csr_seq.sv
// Serialises Zicsr ops, trap entry and mret onto the single-port CSR file.
module rip_csr_seq
  import rip_csr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  rip_csr_seq_if.slave       bus
);

  csr_seq_state_t    state_q;
  csr_op_t           op_q;
  logic [XLEN-1:0]   wdata_q;
  logic              wr_en_q;
  logic [XLEN-1:0]   cause_q;
  logic [XLEN-1:0]   tval_q;
  logic [XLEN-1:0]   target_q;
  logic              trap_mode_q;

  logic              csr_rsp_valid_q;
  logic [XLEN-1:0]   csr_rsp_rdata_q;
  logic              redirect_valid_q;
  logic              cf_write_q;
  logic              cf_set_q;
  logic              cf_clear_q;
  logic [CSR_AW-1:0] cf_addr_q;
  logic [XLEN-1:0]   din_q;

  logic              idle;
  logic              trap_gnt;
  logic              mret_gnt;
  logic              csr_gnt;

  // Fixed priority trap > mret > csr, granted only in IDLE and out of reset.
  assign idle     = (state_q == S_IDLE);
  assign trap_gnt = rst_n && idle && bus.trap_valid;
  assign mret_gnt = rst_n && idle && bus.mret_valid && !bus.trap_valid;
  assign csr_gnt  = rst_n && idle && bus.csr_req_valid && !bus.trap_valid && !bus.mret_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      op_q             <= OP_RSVD;
      wdata_q          <= '0;
      wr_en_q          <= 1'b0;
      cause_q          <= '0;
      tval_q           <= '0;
      target_q         <= '0;
      trap_mode_q      <= 1'b0;
      csr_rsp_valid_q  <= 1'b0;
      csr_rsp_rdata_q  <= '0;
      redirect_valid_q <= 1'b0;
      cf_write_q       <= 1'b0;
      cf_set_q         <= 1'b0;
      cf_clear_q       <= 1'b0;
      cf_addr_q        <= '0;
      din_q            <= '0;
    end else begin
      cf_write_q       <= 1'b0;
      cf_set_q         <= 1'b0;
      cf_clear_q       <= 1'b0;
      csr_rsp_valid_q  <= 1'b0;
      redirect_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (trap_gnt) begin
            cause_q    <= bus.trap_cause;
            tval_q     <= bus.trap_tval;
            cf_addr_q  <= CSR_MEPC;
            din_q      <= bus.trap_pc;
            cf_write_q <= 1'b1;
            state_q    <= S_T_EPC;
          end else if (mret_gnt) begin
            cf_addr_q  <= CSR_MEPC;
            state_q    <= S_M_EPC;
          end else if (csr_gnt) begin
            op_q       <= csr_op_t'(bus.csr_req_op);
            wdata_q    <= bus.csr_req_wdata;
            wr_en_q    <= bus.csr_req_wr_en;
            cf_addr_q  <= bus.csr_req_addr;
            state_q    <= S_C_RD;
          end
        end
        S_C_RD: begin
          din_q   <= wdata_q;
          state_q <= S_C_WR;
          case (op_q)
            OP_RW:   cf_write_q <= 1'b1;
            OP_RS:   cf_set_q   <= wr_en_q;
            OP_RC:   cf_clear_q <= wr_en_q;
            default: ;
          endcase
        end
        S_C_WR: begin
          csr_rsp_valid_q <= 1'b1;
          csr_rsp_rdata_q <= (op_q == OP_RSVD) ? '0 : bus.cf_dout;
          state_q         <= S_IDLE;
        end
        S_T_EPC: begin
          cf_addr_q  <= CSR_MCAUSE;
          din_q      <= cause_q;
          cf_write_q <= 1'b1;
          state_q    <= S_T_CAUSE;
        end
        S_T_CAUSE: begin
          cf_addr_q  <= CSR_MTVAL;
          din_q      <= tval_q;
          cf_write_q <= 1'b1;
          state_q    <= S_T_TVAL;
        end
        S_T_TVAL: begin
          cf_addr_q <= CSR_MTVEC;
          state_q   <= S_T_VEC;
        end
        S_T_VEC: begin
          cf_addr_q <= CSR_MSTATUS;
          state_q   <= S_T_STAT;
        end
        S_T_STAT: begin
          target_q         <= trap_target(bus.cf_dout, cause_q);
          trap_mode_q      <= 1'b1;
          cf_write_q       <= 1'b1;
          redirect_valid_q <= 1'b1;
          state_q          <= S_REDIR;
        end
        S_M_EPC: begin
          cf_addr_q <= CSR_MSTATUS;
          state_q   <= S_M_STAT;
        end
        S_M_STAT: begin
          target_q         <= bus.cf_dout;
          trap_mode_q      <= 1'b0;
          cf_write_q       <= 1'b1;
          redirect_valid_q <= 1'b1;
          state_q          <= S_REDIR;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.csr_req_ready  = csr_gnt;
  assign bus.trap_ready     = trap_gnt;
  assign bus.mret_ready     = mret_gnt;
  assign bus.csr_rsp_valid  = csr_rsp_valid_q;
  assign bus.csr_rsp_rdata  = csr_rsp_rdata_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = target_q;
  assign bus.busy           = !idle;
  assign bus.cf_write       = cf_write_q;
  assign bus.cf_set         = cf_set_q;
  assign bus.cf_clear       = cf_clear_q;
  assign bus.cf_addr        = cf_addr_q;
  // mstatus arrives on cf_dout only in REDIR, so its update is formed in that cycle.
  assign bus.cf_din         = (state_q == S_REDIR)
                            ? (trap_mode_q ? mstatus_on_trap(bus.cf_dout)
                                           : mstatus_on_mret(bus.cf_dout))
                            : din_q;

endmodule
